// File: rtl/lease_table_loader.sv
// Streams a lease lookup table image into configuration and table write strobes.
// Optional trailing checksum word checking is enabled with LEASE_LOADER_CHECKSUM_EN.
`ifndef LEASE_LLT_ENTRIES
`define LEASE_LLT_ENTRIES 128
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module lease_table_loader #(
   parameter int N_ENTRIES = `LEASE_LLT_ENTRIES
) (
   input  logic                             clock_i,
   input  logic                             reset_i,
   input  logic                             start_i,
   input  logic [31:0]                      data_i,
   input  logic                             valid_i,
   output logic                             ready_o,
   output logic                             con_wren_o,
   output logic                             llt_wren_o,
   output logic [`CLOG2(N_ENTRIES)+2-1:0]   llt_addr_o,
   output logic [31:0]                      llt_data_o,
   output logic                             busy_o,
   output logic                             done_o,
   output logic                             error_o
);

   localparam int BW_ENTRIES    = `CLOG2(N_ENTRIES);
   localparam int BW_ADDR_SPACE = BW_ENTRIES + 2;

   typedef enum logic [2:0] {
      ST_IDLE, ST_HEADER, ST_CONFIG, ST_TABLE, ST_CHECK, ST_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [BW_ENTRIES:0]     n_q;
   logic [BW_ENTRIES-1:0]   idx_q;
   logic [1:0]              tsel_q;
   logic                    accept;
   logic                    hdr_bad;
   logic                    last_idx;
   logic                    last_beat;
   logic [15:0]             hdr;

   assign hdr       = data_i[15:0];
   assign hdr_bad   = (hdr == 16'd0) || (32'(hdr) > 32'(N_ENTRIES));
   assign last_idx  = ({1'b0, idx_q} == (n_q - 1'b1));
   assign last_beat = last_idx && (tsel_q == 2'd3);
   assign accept    = ready_o & valid_i;

`ifdef LEASE_LOADER_CHECKSUM_EN
   logic [31:0] sum_q;
   logic        sum_ok;
   assign sum_ok = (data_i == sum_q);
`endif

   always_ff @(posedge clock_i) begin
      if (reset_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ready_o = 1'b0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_HEADER;
         end
         ST_HEADER: begin
            ready_o = 1'b1;
            busy_o  = 1'b1;
            if (valid_i) state_d = hdr_bad ? ST_IDLE : ST_CONFIG;
         end
         ST_CONFIG: begin
            ready_o = 1'b1;
            busy_o  = 1'b1;
            if (valid_i) state_d = ST_TABLE;
         end
         ST_TABLE: begin
            ready_o = 1'b1;
            busy_o  = 1'b1;
`ifdef LEASE_LOADER_CHECKSUM_EN
            if (valid_i && last_beat) state_d = ST_CHECK;
`else
            if (valid_i && last_beat) state_d = ST_DONE;
`endif
         end
`ifdef LEASE_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            ready_o = 1'b1;
            busy_o  = 1'b1;
            if (valid_i) state_d = sum_ok ? ST_DONE : ST_IDLE;
         end
`endif
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes, address and data are registered: each lands one cycle after its beat.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         con_wren_o <= 1'b0;
         llt_wren_o <= 1'b0;
         error_o    <= 1'b0;
         llt_addr_o <= '0;
         llt_data_o <= '0;
         n_q        <= '0;
         idx_q      <= '0;
         tsel_q     <= '0;
`ifdef LEASE_LOADER_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         con_wren_o <= 1'b0;
         llt_wren_o <= 1'b0;
         error_o    <= 1'b0;
         if (accept) begin
            case (state_q)
               ST_HEADER: begin
                  if (hdr_bad) error_o <= 1'b1;
                  else         n_q     <= hdr[BW_ENTRIES:0];
                  idx_q  <= '0;
                  tsel_q <= '0;
`ifdef LEASE_LOADER_CHECKSUM_EN
                  sum_q  <= '0;
`endif
               end
               ST_CONFIG: begin
                  con_wren_o <= 1'b1;
                  llt_addr_o <= '0;
                  llt_data_o <= data_i;
`ifdef LEASE_LOADER_CHECKSUM_EN
                  sum_q      <= sum_q + data_i;
`endif
               end
               ST_TABLE: begin
                  llt_wren_o <= 1'b1;
                  llt_addr_o <= {tsel_q, idx_q};
                  llt_data_o <= data_i;
`ifdef LEASE_LOADER_CHECKSUM_EN
                  sum_q      <= sum_q + data_i;
`endif
                  if (last_idx) begin
                     idx_q  <= '0;
                     tsel_q <= tsel_q + 2'd1;
                  end else begin
                     idx_q  <= idx_q + 1'b1;
                  end
               end
`ifdef LEASE_LOADER_CHECKSUM_EN
               ST_CHECK: begin
                  if (!sum_ok) error_o <= 1'b1;
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lease_table_loader.sv
// Directed bench for lease_table_loader (default N_ENTRIES=128).
// Checksum scenarios are compiled in when LEASE_LOADER_CHECKSUM_EN is defined.
module tb_lease_table_loader;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] data_i  = '0;
   logic        valid_i = 1'b0;
   logic        ready_o, con_wren_o, llt_wren_o, busy_o, done_o, error_o;
   logic [8:0]  llt_addr_o;
   logic [31:0] llt_data_o;

   int n_checks = 0;
   int n_fail   = 0;

   lease_table_loader #(.N_ENTRIES(128)) dut (
      .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .data_i(data_i),
      .valid_i(valid_i), .ready_o(ready_o), .con_wren_o(con_wren_o),
      .llt_wren_o(llt_wren_o), .llt_addr_o(llt_addr_o), .llt_data_o(llt_data_o),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
   );

   always #5 clock_i = ~clock_i;

   // Strobe log, sampled on the falling edge.
   logic [8:0]  a_q[$];
   logic [31:0] d_q[$];
   logic [31:0] con_d_q[$];
   int done_cnt, err_cnt, orphan_cnt, both_cnt;
   bit hs_prev = 1'b0;

   always @(negedge clock_i) begin
      if (con_wren_o) con_d_q.push_back(llt_data_o);
      if (llt_wren_o) begin
         a_q.push_back(llt_addr_o);
         d_q.push_back(llt_data_o);
      end
      if ((con_wren_o || llt_wren_o) && !hs_prev) orphan_cnt++;
      if (con_wren_o && llt_wren_o) both_cnt++;
      done_cnt += int'(done_o);
      err_cnt  += int'(error_o);
      hs_prev = valid_i & ready_o;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      a_q.delete(); d_q.delete(); con_d_q.delete();
      done_cnt = 0; err_cnt = 0; orphan_cnt = 0; both_cnt = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clock_i); #1; end
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      idle(1);
      start_i = 1'b0;
   endtask

   // Present one word and hold it until the handshake, then gap idle cycles.
   task automatic send(input logic [31:0] w, input int gap);
      bit hs = 1'b0;
      int t = 0;
      valid_i = 1'b1;
      data_i  = w;
      do begin
         @(negedge clock_i); hs = ready_o;
         @(posedge clock_i); #1; t++;
      end while (!hs && t < 50);
      valid_i = 1'b0;
      if (!hs) chk("handshake_timeout", 0, 1);
      idle(gap);
   endtask

   task automatic load(input int n, input logic [31:0] base, input int gap,
                       input bit good_sum, input bit poke);
      logic [31:0] sum;
      logic [31:0] w;
      sum = 32'd0;
      pulse_start();
      send(32'(n), gap);
      send(base ^ 32'h5, gap);
      sum += base ^ 32'h5;
      if (poke) pulse_start();
      for (int k = 0; k < 4 * n; k++) begin
         w = base + 32'(k);
         send(w, gap);
         sum += w;
         if (poke && k == 1) pulse_start();
      end
`ifdef LEASE_LOADER_CHECKSUM_EN
      send(good_sum ? sum : sum + 32'd1, gap);
`else
      if (!good_sum) sum = 32'd0;
`endif
      idle(3);
   endtask

   task automatic check_log(input string tag, input int n, input logic [31:0] base);
      chk({tag, "_con_cnt"}, con_d_q.size(), 1);
      if (con_d_q.size() > 0) chk({tag, "_con_data"}, con_d_q[0], base ^ 32'h5);
      chk({tag, "_llt_cnt"}, a_q.size(), 4 * n);
      for (int k = 0; k < 4 * n && k < a_q.size(); k++) begin
         chk($sformatf("%s_addr%0d", tag, k), a_q[k], ((k / n) << 7) | (k % n));
         chk($sformatf("%s_data%0d", tag, k), d_q[k], base + 32'(k));
      end
      chk({tag, "_done"}, done_cnt, 1);
      chk({tag, "_err"}, err_cnt, 0);
      chk({tag, "_orphan"}, orphan_cnt, 0);
      chk({tag, "_both"}, both_cnt, 0);
      chk({tag, "_busy_after"}, busy_o, 0);
   endtask

   initial begin
      idle(3);
      chk("reset_outs", {ready_o, con_wren_o, llt_wren_o, busy_o, done_o, error_o,
                         llt_addr_o, llt_data_o}, 64'd0);
      reset_i = 1'b0;
      idle(2);
      chk("idle_ready", ready_o, 0);

      // N=2, continuous valid
      clear_log();
      load(2, 32'h1000_0000, 0, 1'b1, 1'b0);
      check_log("n2", 2, 32'h1000_0000);
      if (a_q.size() == 8) begin
         chk("n2_addr_lease1", a_q[4], 9'h100);
         chk("n2_addr_last", a_q[7], 9'h181);
      end

      // Header N=129: error one cycle after acceptance
      clear_log();
      pulse_start();
      chk("busy_on_start", busy_o, 1);
      send(32'd129, 0);
      chk("n129_err_pulse", error_o, 1);
      chk("n129_busy", busy_o, 0);
      idle(1);
      chk("n129_err_single", error_o, 0);
      idle(2);
      chk("n129_err_cnt", err_cnt, 1);
      chk("n129_no_strobes", a_q.size() + con_d_q.size(), 0);
      chk("n129_no_done", done_cnt, 0);

      // Header N=0
      clear_log();
      pulse_start();
      send(32'd0, 0);
      chk("n0_err_pulse", error_o, 1);
      idle(2);
      chk("n0_err_cnt", err_cnt, 1);
      chk("n0_ready", ready_o, 0);

      // N=1, valid every other cycle
      clear_log();
      load(1, 32'h2000_0040, 1, 1'b1, 1'b0);
      check_log("n1_gap", 1, 32'h2000_0040);
      chk("n1_gap_strobes", a_q.size() + con_d_q.size(), 5);

      // N=128 (largest legal table)
      clear_log();
      load(128, 32'h3000_0000, 0, 1'b1, 1'b0);
      chk("n128_llt_cnt", a_q.size(), 512);
      if (a_q.size() == 512) begin
         chk("n128_addr_127", a_q[127], 9'h07F);
         chk("n128_addr_128", a_q[128], 9'h080);
         chk("n128_addr_last", a_q[511], 9'h1FF);
         chk("n128_data_last", d_q[511], 32'h3000_01FF);
      end
      chk("n128_done", done_cnt, 1);
      chk("n128_err", err_cnt, 0);

      // Reset after the 3rd table beat
      clear_log();
      pulse_start();
      send(32'd2, 0);
      send(32'h77, 0);
      for (int k = 0; k < 3; k++) send(32'h40 + 32'(k), 0);
      reset_i = 1'b1;
      idle(1);
      chk("rst_mid_outs", {ready_o, con_wren_o, llt_wren_o, busy_o, done_o, error_o,
                           llt_addr_o, llt_data_o}, 64'd0);
      reset_i = 1'b0;
      idle(3);
      chk("rst_mid_llt_cnt", a_q.size(), 3);
      chk("rst_mid_done", done_cnt, 0);
      chk("rst_mid_err", err_cnt, 0);

      // Reset wins over start in the same cycle
      reset_i = 1'b1;
      start_i = 1'b1;
      idle(1);
      reset_i = 1'b0;
      start_i = 1'b0;
      idle(1);
      chk("rst_vs_start_busy", busy_o, 0);

      // Fresh load after reset starts from index 0
      clear_log();
      load(1, 32'h5000_0000, 0, 1'b1, 1'b0);
      check_log("fresh", 1, 32'h5000_0000);

      // start_i pulses during a load are ignored
      clear_log();
      load(2, 32'h6000_0000, 1, 1'b1, 1'b1);
      check_log("poke", 2, 32'h6000_0000);

`ifdef LEASE_LOADER_CHECKSUM_EN
      clear_log();
      pulse_start();
      send(32'd1, 0); send(32'd0, 0); send(32'h10, 0);
      send(32'd3, 0); send(32'd4, 0); send(32'h50, 0);
      send(32'h67, 0);
      idle(3);
      chk("sum_good_done", done_cnt, 1);
      chk("sum_good_err", err_cnt, 0);
      clear_log();
      pulse_start();
      send(32'd1, 0); send(32'd0, 0); send(32'h10, 0);
      send(32'd3, 0); send(32'd4, 0); send(32'h50, 0);
      send(32'h68, 0);
      chk("sum_bad_pulse", error_o, 1);
      idle(3);
      chk("sum_bad_done", done_cnt, 0);
      chk("sum_bad_err", err_cnt, 1);
      chk("sum_bad_busy", busy_o, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lease_table_loader.md
LEASE_TABLE_LOADER -- requirements
Module: lease_table_loader

Interface
REQ-001 The module SHALL have parameter N_ENTRIES, default 128 (`LEASE_LLT_ENTRIES), the lease lookup table entries per table.
REQ-002 The module SHALL derive localparams BW_ENTRIES = `CLOG2(N_ENTRIES) and BW_ADDR_SPACE = BW_ENTRIES+2.
REQ-003 Port clock_i, input, 1: single clock; all logic on its rising edge.
REQ-004 Port reset_i, input, 1: synchronous reset, active-high.
REQ-005 Port start_i, input, 1: one-cycle strobe; begins a load when idle.
REQ-006 Port data_i, input, 32: stream word.
REQ-007 Port valid_i, input, 1: data_i valid.
REQ-008 Port ready_o, output, 1: loader accepts data_i; a beat transfers when valid_i & ready_o.
REQ-009 Port con_wren_o, output, 1: configuration register write strobe.
REQ-010 Port llt_wren_o, output, 1: lookup table write strobe.
REQ-011 Port llt_addr_o, output, BW_ADDR_SPACE: {table_sel[1:0], index[BW_ENTRIES-1:0]}; table_sel 0=address, 1=lease0, 2=lease1, 3=lease0_prob.
REQ-012 Port llt_data_o, output, 32: write data.
REQ-013 Port busy_o, output, 1: high from start acceptance until done_o/error_o.
REQ-014 Port done_o, output, 1: one-cycle pulse on successful completion.
REQ-015 Port error_o, output, 1: one-cycle pulse on aborted or failed load.

Function
REQ-016 Stream format SHALL be: header word (count N in [15:0]), default-lease word, N address words, N lease0 words, N lease1 words, N lease0_prob words, then a checksum word only when the configuration macro is defined.
REQ-017 The FSM SHALL have states ST_IDLE, ST_HEADER, ST_CONFIG, ST_TABLE, ST_CHECK, ST_DONE.
REQ-018 In ST_IDLE, start_i SHALL move the FSM to ST_HEADER and assert busy_o; start_i while busy_o is high SHALL be ignored.
REQ-019 ready_o SHALL be high only in ST_HEADER, ST_CONFIG, ST_TABLE and ST_CHECK.
REQ-020 In ST_HEADER, N==0 or N>N_ENTRIES SHALL pulse error_o and return to ST_IDLE; otherwise the FSM SHALL latch N and go to ST_CONFIG.
REQ-021 A beat accepted in ST_CONFIG SHALL cause, on the next cycle, con_wren_o=1, llt_addr_o=0, llt_data_o=word; the FSM then goes to ST_TABLE with table_sel=0 and index=0.
REQ-022 Each beat accepted in ST_TABLE SHALL cause, on the next cycle, llt_wren_o=1 with llt_addr_o={table_sel,index} and llt_data_o=word.
REQ-023 Index SHALL increment per beat; at index==N-1 it SHALL wrap to 0 and table_sel SHALL increment.
REQ-024 After the beat at table_sel=3 and index=N-1, the FSM SHALL go to ST_CHECK if the macro is defined, otherwise to ST_DONE.
REQ-025 ST_DONE SHALL pulse done_o for one cycle, clear busy_o and return to ST_IDLE.
REQ-026 Write strobes SHALL be single-cycle, at most one per cycle; con_wren_o and llt_wren_o are never high together.
REQ-027 valid_i low SHALL stall the FSM with no strobe issued and no counter change.
REQ-028 Gaps between beats of any length SHALL be tolerated.

Reset
REQ-029 reset_i SHALL force ST_IDLE and ready_o, con_wren_o, llt_wren_o, busy_o, done_o, error_o to 0, llt_addr_o to 0, llt_data_o to 0, and all counters to 0.
REQ-030 reset_i mid-load SHALL abandon the load with no further strobes and no done_o/error_o pulse; already-written entries remain written.
REQ-031 reset_i SHALL take priority over start_i in the same cycle.

Configuration
REQ-032 The macro SHALL be LEASE_LOADER_CHECKSUM_EN.
REQ-033 With LEASE_LOADER_CHECKSUM_EN defined, a 32-bit running sum (mod 2^32) of all words after the header SHALL be kept.
REQ-034 With the macro defined, ST_CHECK SHALL accept one word; a match SHALL go to ST_DONE and a mismatch SHALL pulse error_o, with no done_o, and return to ST_IDLE.
REQ-035 Without the macro, ST_CHECK and the summing logic SHALL be absent and done_o SHALL follow the final table beat.

Verification
REQ-036 Load with N=2, continuous valid: words 2, 5, A0, A1, L0a, L0b, L1a, L1b, P0, P1 -> con_wren at addr 0 with data 5; llt_wren at 0x000, 0x001, 0x080, 0x081, 0x100, 0x101, 0x180, 0x181 (N_ENTRIES=128); one done_o pulse.
REQ-037 Header N=129 -> error_o pulse one cycle after acceptance, no write strobes, busy_o low afterward.
REQ-038 N=1 with valid_i toggled every other cycle -> exactly 5 strobes, one per accepted beat, each one cycle after its handshake.
REQ-039 reset_i asserted after the 3rd table beat -> all outputs 0 next cycle; no done_o; a subsequent start_i begins a fresh load.
REQ-040 With macro defined, N=1, words 1, 0, 0x10, 3, 4, 0x50 -> checksum 0x67 gives done_o; checksum 0x68 gives error_o and no done_o.
REQ-041 start_i pulsed while busy_o is high -> no effect on the current load or on the counters.
